cmd_display_scan: RTL

CMD_DISPLAY_SCAN -- requirements
Module: cmd_display_scan

---
 rtl/cmd_display_scan_if.sv | 30 +++
 rtl/cmd_display_scan.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cmd_display_scan_if.sv
// Display-scan bus: command load, mode controls and multiplexed seven-segment outputs.
interface cmd_display_scan_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CMD_W  = 7
);
  localparam int unsigned AD = (ADDR_W + 3) / 4;
  localparam int unsigned CD = (CMD_W + 3) / 4;
  localparam int unsigned N  = AD + CD;
  localparam int unsigned W  = ADDR_W + CMD_W;

  logic         load;
  logic [W-1:0] cmd_in;
  logic         lz_blank;
  logic         blink_en;
  logic [6:0]   seg;
  logic         dp;
  logic [N-1:0] digit_sel;
  logic [W-1:0] shown;
  logic         frame_tick;

  modport master (
    output load, cmd_in, lz_blank, blink_en,
    input  seg, dp, digit_sel, shown, frame_tick
  );

  modport slave (
    input  load, cmd_in, lz_blank, blink_en,
    output seg, dp, digit_sel, shown, frame_tick
  );
endinterface

// File: rtl/cmd_display_scan.sv
// Multiplexed hex display of a latched {address, command} word with
// leading-zero blanking, a field-separator point and whole-display blinking.
module cmd_display_scan #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned CMD_W     = 7,
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLINK_DIV = 64
) (
  input  logic                clk,
  input  logic                rst,
  cmd_display_scan_if.slave   bus
);
  localparam int unsigned AD     = (ADDR_W + 3) / 4;
  localparam int unsigned CD     = (CMD_W + 3) / 4;
  localparam int unsigned N      = AD + CD;
  localparam int unsigned W      = ADDR_W + CMD_W;
  localparam int unsigned AD_PW  = 4 * AD;
  localparam int unsigned CD_PW  = 4 * CD;
  localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = $clog2(N);
  localparam int unsigned BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [W-1:0]      r_shown;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [BCNT_W-1:0] r_bcnt;
  logic              r_phase;
  logic [6:0]        r_seg;
  logic              r_dp;
  logic [N-1:0]      r_digit_sel;
  logic              r_frame_tick;

  logic              w_term;
  logic              w_last;
  logic              w_wrap;
  logic              w_bterm;
  logic [AD_PW-1:0]  w_addr_pad;
  logic [CD_PW-1:0]  w_cmd_pad;
  logic [AD_PW-1:0]  w_addr_hi;
  logic [CD_PW-1:0]  w_cmd_hi;
  logic [3:0]        w_nib;
  logic              w_lz;
  logic [6:0]        w_seg;
  logic              w_dp;
  logic [N-1:0]      w_digit_sel;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  assign w_term     = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_last     = (r_idx == IDX_W'(N - 1));
  assign w_wrap     = w_term && w_last;
  assign w_bterm    = (r_bcnt == BCNT_W'(BLINK_DIV - 1));
  assign w_addr_pad = AD_PW'(r_shown[W-1:CMD_W]);
  assign w_cmd_pad  = CD_PW'(r_shown[CMD_W-1:0]);

  // Select the current nibble; "hi" holds it plus every more significant nibble of its field.
  always_comb begin
    w_addr_hi = '0;
    w_cmd_hi  = '0;
    w_nib     = '0;
    w_lz      = 1'b0;
    if (r_idx < IDX_W'(AD)) begin
      w_addr_hi = w_addr_pad >> (4 * (AD - 1 - 32'(r_idx)));
      w_nib     = w_addr_hi[3:0];
      w_lz      = (w_addr_hi == '0) && (r_idx != IDX_W'(AD - 1));
    end else begin
      w_cmd_hi  = w_cmd_pad >> (4 * (N - 1 - 32'(r_idx)));
      w_nib     = w_cmd_hi[3:0];
      w_lz      = (w_cmd_hi == '0) && (r_idx != IDX_W'(N - 1));
    end
  end

  always_comb begin
    w_seg       = (w_lz && bus.lz_blank) ? 7'h7F : hex7(w_nib);
    w_dp        = (r_idx != IDX_W'(AD - 1));
    w_digit_sel = ~(N'(1) << r_idx);
    if (bus.blink_en && r_phase) begin
      w_seg = 7'h7F;
      w_dp  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shown      <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_bcnt       <= '0;
      r_phase      <= 1'b0;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_digit_sel  <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      if (bus.load) r_shown <= bus.cmd_in;

      if (w_term) begin
        r_cnt <= '0;
        r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_frame_tick <= w_wrap;

      // A load restarts the blink cycle in its visible half, even on a frame wrap.
      if (bus.load) begin
        r_bcnt  <= '0;
        r_phase <= 1'b0;
      end else if (w_wrap) begin
        if (w_bterm) begin
          r_bcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_bcnt <= r_bcnt + BCNT_W'(1);
        end
      end

      r_seg       <= w_seg;
      r_dp        <= w_dp;
      r_digit_sel <= w_digit_sel;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.digit_sel  = r_digit_sel;
  assign bus.shown      = r_shown;
  assign bus.frame_tick = r_frame_tick;
endmodule
